jt49_bus_seq: RTL and testbench

Bus sequencer and arbiter in front of the jt49 PSG register interface. Two requesters share one PSG: port A (host CPU, reads and writes) and port B (write-only, e.g. a music playback engine). The block accepts one request at a time over a valid/ready handshake and arbitrates between the ports. It then drives the PSG's `cs_n`/`wr_n`/`addr`/`din` strobes as a fixed-shape cycle. Every write presents `wr_n` high with `cs_n` low before `wr_n` falls, so the PSG's write-edge detector, including envelope restart on register 13, fires on every write.

---
 rtl/jt49_bus_seq.sv | 122 ++++++++++++
 tb/tb_jt49_bus_seq.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt49_bus_seq.sv
// jt49_bus_seq: two-port request arbiter and fixed-shape PSG bus cycle sequencer.
// Port A reads/writes, port B writes; one transfer at a time towards the PSG.
//
// Ports:
//   rst_n, clk                        async active-low reset, single clock
//   a_valid/a_ready/a_rd/a_addr/a_din  port A request (read or write)
//   a_dout/a_dvalid                    port A read data and its one-cycle pulse
//   b_valid/b_ready/b_addr/b_din       port B write request
//   psg_cs_n/psg_wr_n/psg_addr/psg_din registered PSG strobes and payload
//   psg_dout                           PSG read data
//   busy                               high while a transfer is in flight
module jt49_bus_seq #(
  parameter int unsigned STRB = 1,
  parameter int unsigned GAP  = 0,
  parameter bit          RR   = 1'b1
) (
  input  logic       rst_n,
  input  logic       clk,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic       a_rd,
  input  logic [3:0] a_addr,
  input  logic [7:0] a_din,
  output logic [7:0] a_dout,
  output logic       a_dvalid,
  input  logic       b_valid,
  output logic       b_ready,
  input  logic [3:0] b_addr,
  input  logic [7:0] b_din,
  output logic       psg_cs_n,
  output logic       psg_wr_n,
  output logic [3:0] psg_addr,
  output logic [7:0] psg_din,
  input  logic [7:0] psg_dout,
  output logic       busy
);

  localparam logic [3:0] STRB_N = 4'(STRB);
  localparam logic [3:0] GAP_N  = 4'(GAP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STRB,
    S_READ,
    S_REL,
    S_GAP
  } state_t;

  state_t     state;
  state_t     state_n;
  logic       op_rd;
  logic       last_b;
  logic [3:0] scnt;
  logic [3:0] gcnt;
  logic       grant_a;
  logic       grant_b;
  logic       idle;

  // Round-robin: on a tie the port not served last wins.
  always_comb begin
    grant_a = a_valid & (~RR | ~b_valid | last_b);
    grant_b = b_valid & ~grant_a;
  end

  assign idle    = (state == S_IDLE);
  assign a_ready = rst_n & idle & grant_a;
  assign b_ready = rst_n & idle & grant_b;
  assign busy    = ~idle;

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (a_ready | b_ready) state_n = S_SETUP;
      S_SETUP: state_n = op_rd ? S_READ : S_STRB;
      S_STRB:  if (scnt == 4'd1) state_n = S_REL;
      S_READ:  state_n = S_REL;
      S_REL:   state_n = (GAP_N == 4'd0) ? S_IDLE : S_GAP;
      S_GAP:   if (gcnt == 4'd1) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      psg_cs_n <= 1'b1;
      psg_wr_n <= 1'b1;
      psg_addr <= 4'd0;
      psg_din  <= 8'd0;
      op_rd    <= 1'b0;
      last_b   <= 1'b1;
      scnt     <= 4'd0;
      gcnt     <= 4'd0;
      a_dout   <= 8'd0;
      a_dvalid <= 1'b0;
    end else begin
      state    <= state_n;
      // Strobes follow the next state so they are glitch-free registers.
      psg_cs_n <= !(state_n inside {S_SETUP, S_STRB, S_READ});
      psg_wr_n <= (state_n != S_STRB);
      a_dvalid <= (state == S_READ);
      if (state == S_READ) a_dout <= psg_dout;
      if (a_ready) begin
        psg_addr <= a_addr;
        psg_din  <= a_din;
        op_rd    <= a_rd;
        last_b   <= 1'b0;
      end else if (b_ready) begin
        psg_addr <= b_addr;
        psg_din  <= b_din;
        op_rd    <= 1'b0;
        last_b   <= 1'b1;
      end
      if (state != S_STRB && state_n == S_STRB) scnt <= STRB_N;
      else if (state == S_STRB) scnt <= scnt - 4'd1;
      if (state != S_GAP && state_n == S_GAP) gcnt <= GAP_N;
      else if (state == S_GAP) gcnt <= gcnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_jt49_bus_seq.sv
// tb_jt49_bus_seq: two sequencer instances (1/0/RR and 3/2/fixed) with a PSG
// model, a transaction-level timing model, vector table and random traffic.
module tb_jt49_bus_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       av[2], ard[2], bv[2];
  logic [3:0] aad[2], bad[2];
  logic [7:0] adi[2], bdi[2];
  logic       ardy[2], brdy[2], adv[2], cs[2], wr[2], bsy[2];
  logic [7:0] ado[2], pd[2], pdo[2];
  logic [3:0] pa[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    jt49_bus_seq #(
      .STRB(g ? 3 : 1),
      .GAP (g ? 2 : 0),
      .RR  (g ? 1'b0 : 1'b1)
    ) u_dut (
      .rst_n   (rst_n),
      .clk     (clk),
      .a_valid (av[g]),
      .a_ready (ardy[g]),
      .a_rd    (ard[g]),
      .a_addr  (aad[g]),
      .a_din   (adi[g]),
      .a_dout  (ado[g]),
      .a_dvalid(adv[g]),
      .b_valid (bv[g]),
      .b_ready (brdy[g]),
      .b_addr  (bad[g]),
      .b_din   (bdi[g]),
      .psg_cs_n(cs[g]),
      .psg_wr_n(wr[g]),
      .psg_addr(pa[g]),
      .psg_din (pd[g]),
      .psg_dout(pdo[g]),
      .busy    (bsy[g])
    );
  end

  // PSG model: a write lands on a wr_n fall preceded by a cs_n-low/wr_n-high cycle.
  logic [7:0] preg[2][16];
  logic       setup_ok[2];
  int         pw[2]  = '{0, 0};
  int         env[2] = '{0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        for (int r = 0; r < 16; r++) preg[i][r] <= 8'h00;
        setup_ok[i] <= 1'b0;
      end else begin
        if (!cs[i] && !wr[i] && setup_ok[i]) begin
          preg[i][pa[i]] <= pd[i];
          pw[i] <= pw[i] + 1;
          if (pa[i] == 4'd13) env[i] <= env[i] + 1;
        end
        setup_ok[i] <= !cs[i] && wr[i];
      end
      pdo[i] <= preg[i][pa[i]];
    end
  end

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endfunction

  // Transaction model: t counts cycles since accept (0 = idle).
  int         mt[2], mlen[2], mw[2];
  bit         mrd[2], mlb[2];
  logic [3:0] maddr[2];
  logic [7:0] mdat[2];
  logic [7:0] mregs[2][16];

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        int s  = (i == 1) ? 3 : 1;
        int gp = (i == 1) ? 2 : 0;
        bit rr = (i == 0);
        bit ga, gb;
        if (!rst_n) begin
          mt[i] = 0;
          mlb[i] = 1'b1;
          for (int r = 0; r < 16; r++) mregs[i][r] = 8'h00;
        end else if (mt[i] == 0) begin
          ga = av[i] && (!rr || !bv[i] || mlb[i]);
          gb = bv[i] && !ga;
          chk("a_ready", ardy[i], ga);
          chk("b_ready", brdy[i], gb);
          chk("busy_idle", bsy[i], 0);
          chk("cs_idle", cs[i], 1);
          chk("wr_idle", wr[i], 1);
          chk("dvalid_idle", adv[i], 0);
          if (ga || gb) begin
            mt[i]    = 1;
            mrd[i]   = ga && ard[i];
            maddr[i] = ga ? aad[i] : bad[i];
            mdat[i]  = ga ? adi[i] : bdi[i];
            mlb[i]   = gb;
            mlen[i]  = mrd[i] ? 4 + gp : 3 + s + gp;
          end
        end else begin
          int t = mt[i];
          bit ecs = mrd[i] ? (t <= 2) : (t <= 1 + s);
          bit ewr = !mrd[i] && t >= 2 && t <= 1 + s;
          bit edv = mrd[i] && t == 3;
          chk("busy", bsy[i], 1);
          chk("a_ready_busy", ardy[i], 0);
          chk("b_ready_busy", brdy[i], 0);
          chk("cs_n", cs[i], !ecs);
          chk("wr_n", wr[i], !ewr);
          chk("dvalid", adv[i], edv);
          chk("psg_addr", pa[i], maddr[i]);
          if (!mrd[i]) chk("psg_din", pd[i], mdat[i]);
          if (edv) chk("a_dout", ado[i], mregs[i][maddr[i]]);
          if (!mrd[i] && t == 2) begin
            mregs[i][maddr[i]] = mdat[i];
            mw[i]++;
          end
          mt[i] = (t == mlen[i] - 1) ? 0 : t + 1;
        end
      end
    end
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while (bsy[i] && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_timeout", bsy[i], 0);
  endtask

  task automatic req(input int i, input bit p, input bit rd,
                     input logic [3:0] ad, input logic [7:0] d,
                     output int lat, output logic [7:0] rdat,
                     output int dvc);
    bit acc = 1'b0;
    int n = 0;
    rdat = 8'h00;
    dvc = 0;
    if (p) begin
      bv[i] = 1'b1; bad[i] = ad; bdi[i] = d;
    end else begin
      av[i] = 1'b1; ard[i] = rd; aad[i] = ad; adi[i] = d;
    end
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = p ? brdy[i] : ardy[i];
      @(posedge clk);
      #1;
      n++;
    end
    av[i] = 1'b0;
    bv[i] = 1'b0;
    chk("accept_timeout", acc, 1);
    lat = 1;
    while (bsy[i] && lat < 60) begin
      if (adv[i]) begin
        rdat = ado[i];
        dvc = lat;
      end
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic contend(input int i, input int na, input string exp);
    string got = "";
    int served = 0;
    int k = 0;
    bit aa, bb;
    av[i] = 1'b1; ard[i] = 1'b0; aad[i] = 4'd1; adi[i] = 8'hA0;
    bv[i] = 1'b1; bad[i] = 4'd2; bdi[i] = 8'hB0;
    for (int c = 0; c < 200 && k < 4; c++) begin
      @(negedge clk);
      aa = ardy[i];
      bb = brdy[i];
      @(posedge clk);
      #1;
      if (aa) begin
        got = {got, "A"};
        served++;
        adi[i] = adi[i] + 8'd1;
        if (served == na) av[i] = 1'b0;
        k++;
      end
      if (bb) begin
        got = {got, "B"};
        bdi[i] = bdi[i] + 8'd1;
        k++;
      end
    end
    av[i] = 1'b0;
    bv[i] = 1'b0;
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL grant_order%0d act=%s exp=%s", i, got, exp);
    end
    wait_idle(i);
  endtask

  typedef struct {
    int         inst;
    bit         port;
    bit         rd;
    logic [3:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    int         lat;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int lat, dvc, e0, w0, k;
    int cyc[2];
    logic [7:0] rdat;
    bit acc;

    tbl[0] = '{0, 1'b1, 1'b0, 4'd0,  8'h5A, 8'h00, 4};
    tbl[1] = '{0, 1'b0, 1'b0, 4'd7,  8'h38, 8'h00, 4};
    tbl[2] = '{0, 1'b0, 1'b1, 4'd7,  8'h00, 8'h38, 4};
    tbl[3] = '{0, 1'b1, 1'b0, 4'd15, 8'hFF, 8'h00, 4};
    tbl[4] = '{0, 1'b0, 1'b1, 4'd0,  8'h00, 8'h5A, 4};
    tbl[5] = '{1, 1'b1, 1'b0, 4'd3,  8'hC3, 8'h00, 8};
    tbl[6] = '{1, 1'b0, 1'b1, 4'd3,  8'h00, 8'hC3, 6};
    tbl[7] = '{1, 1'b0, 1'b0, 4'd13, 8'h0E, 8'h00, 8};
    tbl[8] = '{1, 1'b0, 1'b1, 4'd15, 8'h00, 8'h00, 6};

    for (int i = 0; i < 2; i++) begin
      av[i] = 1'b0; ard[i] = 1'b0; aad[i] = 4'd0; adi[i] = 8'd0;
      bv[i] = 1'b0; bad[i] = 4'd0; bdi[i] = 8'd0;
      mw[i] = 0; mt[i] = 0; mlb[i] = 1'b1;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    fork
      monitor();
    join_none
    #2;
    for (int i = 0; i < 2; i++) begin
      av[i] = 1'b1;
      bv[i] = 1'b1;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_cs", cs[i], 1);
      chk("rst_wr", wr[i], 1);
      chk("rst_addr", pa[i], 0);
      chk("rst_din", pd[i], 0);
      chk("rst_dout", ado[i], 0);
      chk("rst_dvalid", adv[i], 0);
      chk("rst_busy", bsy[i], 0);
      chk("rst_a_ready", ardy[i], 0);
      chk("rst_b_ready", brdy[i], 0);
      av[i] = 1'b0;
      bv[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    contend(0, 99, "ABAB");
    contend(1, 3, "AAAB");

    for (int v = 0; v < 9; v++) begin
      req(tbl[v].inst, tbl[v].port, tbl[v].rd, tbl[v].addr, tbl[v].din,
          lat, rdat, dvc);
      chk("latency", lat, tbl[v].lat);
      if (tbl[v].rd) begin
        chk("rd_data", rdat, tbl[v].dout);
        chk("rd_dvalid_cycle", dvc, 3);
      end else begin
        chk("psg_reg", preg[tbl[v].inst][tbl[v].addr], tbl[v].din);
      end
    end

    e0 = env[1];
    k = 0;
    cyc[0] = 0;
    cyc[1] = 0;
    av[1] = 1'b1; ard[1] = 1'b0; aad[1] = 4'd13; adi[1] = 8'h0E;
    for (int c = 0; c < 60 && k < 2; c++) begin
      @(negedge clk);
      acc = ardy[1];
      @(posedge clk);
      #1;
      if (acc) begin
        cyc[k] = c;
        k++;
      end
    end
    av[1] = 1'b0;
    wait_idle(1);
    chk("r13_accepts", k, 2);
    chk("r13_spacing", cyc[1] - cyc[0], 8);
    chk("env_restarts", env[1] - e0, 2);

    bv[0] = 1'b1; bad[0] = 4'd4; bdi[0] = 8'h77;
    acc = 1'b0;
    for (int c = 0; c < 20 && !acc; c++) begin
      @(negedge clk);
      acc = brdy[0];
      @(posedge clk);
      #1;
    end
    bv[0] = 1'b0;
    chk("rst_test_accept", acc, 1);
    @(posedge clk);
    #1;
    chk("pre_rst_wr", wr[0], 0);
    w0 = pw[0];
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cs", cs[0], 1);
    chk("mid_rst_wr", wr[0], 1);
    chk("mid_rst_busy", bsy[0], 0);
    av[0] = 1'b1;
    #1;
    chk("mid_rst_a_ready", ardy[0], 0);
    av[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("no_write_after_rst", pw[0] - w0, 0);

    for (int c = 0; c < 600; c++) begin
      bit aa[2];
      bit bb[2];
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        aa[i] = av[i] && ardy[i];
        bb[i] = bv[i] && brdy[i];
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (aa[i] || (av[i] && $urandom_range(0, 15) == 0)) av[i] = 1'b0;
        else if (!av[i] && $urandom_range(0, 3) == 0) begin
          av[i] = 1'b1;
          ard[i] = 1'($urandom_range(0, 1));
          aad[i] = 4'($urandom);
          adi[i] = 8'($urandom);
        end
        if (bb[i] || (bv[i] && $urandom_range(0, 15) == 0)) bv[i] = 1'b0;
        else if (!bv[i] && $urandom_range(0, 3) == 0) begin
          bv[i] = 1'b1;
          bad[i] = 4'($urandom);
          bdi[i] = 8'($urandom);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      av[i] = 1'b0;
      bv[i] = 1'b0;
    end
    wait_idle(0);
    wait_idle(1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) chk("write_count", pw[i], mw[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
